// File: rtl/l2_arb_pkg.sv
// l2_arb_pkg: shared state/op types and default widths for the L2 arbiter
package l2_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;
  typedef enum logic {OP_READ, OP_WRITE} op_t;
  localparam int TNUM_2_DEF = 18;
  localparam int INUM_2_DEF = 26 - TNUM_2_DEF;
  localparam int LINE_DEF = 512;
endpackage

// File: rtl/l2_arbiter.sv
// l2_arbiter: shares one L2 port between I and D L1 caches; L2_ARB_ROUND_ROBIN_EN selects round-robin, else D over I
module l2_arbiter
  import l2_arb_pkg::*;
#(
  parameter int TNUM_2 = TNUM_2_DEF,
  parameter int INUM_2 = 26 - TNUM_2,
  parameter int LINE   = LINE_DEF
)(
  input  logic              clk,
  input  logic              nrst,
  input  logic              read_I_ARB,
  input  logic [TNUM_2-1:0] tag_I_ARB,
  input  logic [INUM_2-1:0] index_I_ARB,
  output logic              ready_ARB_I,
  output logic [LINE-1:0]   read_data_ARB_I,
  input  logic              read_D_ARB,
  input  logic              write_D_ARB,
  input  logic [TNUM_2-1:0] tag_D_ARB,
  input  logic [INUM_2-1:0] index_D_ARB,
  input  logic [LINE-1:0]   write_data_D_ARB,
  output logic              ready_ARB_D,
  output logic [LINE-1:0]   read_data_ARB_D,
  output logic              read_ARB_L2,
  output logic              write_ARB_L2,
  output logic [TNUM_2-1:0] tag_ARB_L2,
  output logic [INUM_2-1:0] index_ARB_L2,
  output logic [LINE-1:0]   write_data_ARB_L2,
  input  logic              ready_L2_ARB,
  input  logic [LINE-1:0]   read_data_L2_ARB
);
  state_t state, state_nxt;
  op_t op_q;
  logic [TNUM_2-1:0] tag_q;
  logic [INUM_2-1:0] index_q;
  logic [LINE-1:0] wdata_q;
  logic pending, d_req, grant_d, granted;
  assign d_req = read_D_ARB | write_D_ARB;
  assign pending = read_I_ARB | d_req;
`ifdef L2_ARB_ROUND_ROBIN_EN
  logic ptr, side;
  assign grant_d = d_req & (~read_I_ARB | ptr);
  // ptr=1 favours D; it flips toward the side that did not just complete
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      ptr <= 1'b0;
      side <= 1'b0;
    end else begin
      if (state == IDLE && pending) side <= grant_d;
      if (state == DONE) ptr <= ~side;
    end
`else
  assign grant_d = d_req;
`endif
  // next state: arbitrate in IDLE, hold grant until L2 ready, one DONE cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = !pending ? IDLE : grant_d ? GRANT_D : GRANT_I;
      GRANT_I,
      GRANT_D: state_nxt = ready_L2_ARB ? DONE : state;
      default: state_nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) state <= IDLE;
    else state <= state_nxt;
  // capture the winner's request at grant; requester changes afterwards are ignored
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      op_q <= OP_READ;
      tag_q <= '0;
      index_q <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && pending) begin
      op_q <= (grant_d && write_D_ARB) ? OP_WRITE : OP_READ;
      tag_q <= grant_d ? tag_D_ARB : tag_I_ARB;
      index_q <= grant_d ? index_D_ARB : index_I_ARB;
      wdata_q <= (grant_d && write_D_ARB) ? write_data_D_ARB : '0;
    end
  assign granted = state == GRANT_I || state == GRANT_D;
  assign read_ARB_L2 = granted && op_q == OP_READ;
  assign write_ARB_L2 = granted && op_q == OP_WRITE;
  assign tag_ARB_L2 = tag_q;
  assign index_ARB_L2 = index_q;
  assign write_data_ARB_L2 = wdata_q;
  assign ready_ARB_I = state == GRANT_I && ready_L2_ARB;
  assign ready_ARB_D = state == GRANT_D && ready_L2_ARB;
  assign read_data_ARB_I = read_data_L2_ARB;
  assign read_data_ARB_D = read_data_L2_ARB;
endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: scoreboard bench for l2_arbiter; expectations follow L2_ARB_ROUND_ROBIN_EN
module tb_l2_arbiter;
  logic clk = 0, nrst = 0;
  logic read_I_ARB, read_D_ARB, write_D_ARB, ready_L2_ARB;
  logic [17:0] tag_I_ARB, tag_D_ARB, tag_ARB_L2;
  logic [7:0] index_I_ARB, index_D_ARB, index_ARB_L2;
  logic [511:0] write_data_D_ARB, read_data_L2_ARB, write_data_ARB_L2, read_data_ARB_I, read_data_ARB_D;
  logic ready_ARB_I, ready_ARB_D, read_ARB_L2, write_ARB_L2;
  int tests = 0, fails = 0, ncyc = 0;
  typedef struct {logic d; logic wr; logic [17:0] tag; logic [7:0] idx; logic [511:0] wd; logic [511:0] rd; int lat;} exp_t;
  exp_t q[$];
  exp_t e;
  localparam logic [511:0] DB = {16{32'hDEADBEEF}};
  localparam logic [511:0] A5 = {64{8'hA5}};

  l2_arbiter dut (
    .clk(clk), .nrst(nrst),
    .read_I_ARB(read_I_ARB), .tag_I_ARB(tag_I_ARB), .index_I_ARB(index_I_ARB),
    .ready_ARB_I(ready_ARB_I), .read_data_ARB_I(read_data_ARB_I),
    .read_D_ARB(read_D_ARB), .write_D_ARB(write_D_ARB), .tag_D_ARB(tag_D_ARB),
    .index_D_ARB(index_D_ARB), .write_data_D_ARB(write_data_D_ARB),
    .ready_ARB_D(ready_ARB_D), .read_data_ARB_D(read_data_ARB_D),
    .read_ARB_L2(read_ARB_L2), .write_ARB_L2(write_ARB_L2), .tag_ARB_L2(tag_ARB_L2),
    .index_ARB_L2(index_ARB_L2), .write_data_ARB_L2(write_data_ARB_L2),
    .ready_L2_ARB(ready_L2_ARB), .read_data_L2_ARB(read_data_L2_ARB)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(logic d, logic wr, logic [17:0] tag, logic [7:0] idx, logic [511:0] wd, logic [511:0] rd, int lat);
    exp_t x;
    x.d = d; x.wr = wr; x.tag = tag; x.idx = idx; x.wd = wd; x.rd = rd; x.lat = lat;
    return x;
  endfunction

  task automatic wait_grant;
    int n = 0;
    while (!(read_ARB_L2 || write_ARB_L2) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 20) begin
      tests++; fails++;
      $display("FAIL grant_timeout: no grant after %0d cycles", n);
    end
  endtask

  task automatic complete(int lat, logic [511:0] d, int hold);
    repeat (lat - 1) begin @(posedge clk); #1; end
    read_data_L2_ARB = d;
    ready_L2_ARB = 1;
    repeat (hold) begin @(posedge clk); #1; end
    ready_L2_ARB = 0;
    read_data_L2_ARB = '0;
  endtask

  task automatic chk_quiet(string name);
    chk({name, "_l2_req"}, 512'({read_ARB_L2, write_ARB_L2}), 512'(0));
    chk({name, "_ready"}, 512'({ready_ARB_I, ready_ARB_D}), 512'(0));
    chk({name, "_tag"}, 512'(tag_ARB_L2), 512'(0));
    chk({name, "_index"}, 512'(index_ARB_L2), 512'(0));
    chk({name, "_wdata"}, write_data_ARB_L2, 512'(0));
  endtask

  // monitor: compares every grant cycle against the queue head, pops on completion
  always @(negedge clk) begin
    if (!nrst) ncyc = 0;
    else if (read_ARB_L2 || write_ARB_L2) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_grant: tag %h with empty scoreboard", tag_ARB_L2);
      end else begin
        e = q[0];
        ncyc++;
        chk("op", 512'({read_ARB_L2, write_ARB_L2}), e.wr ? 512'(1) : 512'(2));
        chk("tag", 512'(tag_ARB_L2), 512'(e.tag));
        chk("index", 512'(index_ARB_L2), 512'(e.idx));
        if (e.wr) chk("wdata", write_data_ARB_L2, e.wd);
        if (ready_L2_ARB) begin
          chk("ready_side", 512'({ready_ARB_I, ready_ARB_D}), e.d ? 512'(1) : 512'(2));
          chk("rdata", e.d ? read_data_ARB_D : read_data_ARB_I, e.rd);
          chk("grant_cycles", 512'(ncyc), 512'(e.lat));
          void'(q.pop_front());
          ncyc = 0;
        end
      end
    end else
      chk("no_ready_outside_grant", 512'({ready_ARB_I, ready_ARB_D}), 512'(0));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "timeout");
  end

  initial begin
    read_I_ARB = 1; read_D_ARB = 1; write_D_ARB = 1; ready_L2_ARB = 0;
    tag_I_ARB = 18'h00111; index_I_ARB = 8'h11;
    tag_D_ARB = 18'h00222; index_D_ARB = 8'h22;
    write_data_D_ARB = {64{8'h3C}}; read_data_L2_ARB = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
`ifdef L2_ARB_ROUND_ROBIN_EN
    q.push_back(mk(0, 0, 18'h00111, 8'h11, '0, 512'h1, 2));
`else
    q.push_back(mk(1, 1, 18'h00222, 8'h22, {64{8'h3C}}, 512'h1, 2));
`endif
    nrst = 1;
    @(posedge clk); #1;
    chk("grant_one_edge_after_reset", 512'(read_ARB_L2 | write_ARB_L2), 512'(1));
    complete(2, 512'h1, 1);
    read_I_ARB = 0; read_D_ARB = 0; write_D_ARB = 0;
    @(posedge clk); #1;

    read_I_ARB = 1; tag_I_ARB = 18'h2A5F1; index_I_ARB = 8'h13;
    q.push_back(mk(0, 0, 18'h2A5F1, 8'h13, '0, DB, 4));
    wait_grant();
    complete(4, DB, 1);
    chk("done_no_l2_req", 512'({read_ARB_L2, write_ARB_L2}), 512'(0));
    read_I_ARB = 0;
    @(posedge clk); #1;

    write_D_ARB = 1; read_D_ARB = 1; tag_D_ARB = 18'h3C0DE; index_D_ARB = 8'h44; write_data_D_ARB = A5;
    q.push_back(mk(1, 1, 18'h3C0DE, 8'h44, A5, 512'h2, 2));
    q.push_back(mk(1, 0, 18'h3C0DE, 8'h44, '0, 512'h3, 2));
    wait_grant();
    complete(2, 512'h2, 1);
    write_D_ARB = 0;
    wait_grant();
    complete(2, 512'h3, 1);
    read_D_ARB = 0;
    @(posedge clk); #1;

    read_I_ARB = 1; tag_I_ARB = 18'h01234; index_I_ARB = 8'h01;
    read_D_ARB = 1; tag_D_ARB = 18'h05678; index_D_ARB = 8'h02;
    for (int i = 0; i < 4; i++) begin
`ifdef L2_ARB_ROUND_ROBIN_EN
      if (i % 2 == 0) q.push_back(mk(0, 0, 18'h01234, 8'h01, '0, 512'(i + 16), 2));
      else q.push_back(mk(1, 0, 18'h05678, 8'h02, '0, 512'(i + 16), 2));
`else
      q.push_back(mk(1, 0, 18'h05678, 8'h02, '0, 512'(i + 16), 2));
`endif
    end
    for (int i = 0; i < 4; i++) begin
      wait_grant();
      complete(2, 512'(i + 16), 1);
    end
    read_I_ARB = 0; read_D_ARB = 0;
    @(posedge clk); #1;

    read_I_ARB = 1; tag_I_ARB = 18'h0ABCD; index_I_ARB = 8'h05;
    q.push_back(mk(0, 0, 18'h0ABCD, 8'h05, '0, 512'h55, 3));
    wait_grant();
    index_I_ARB = 8'h1F; tag_I_ARB = 18'h3FFFF; read_I_ARB = 0;
    complete(3, 512'h55, 2);
    @(posedge clk); #1;

    read_D_ARB = 1; tag_D_ARB = 18'h1BEEF; index_D_ARB = 8'h66;
    q.push_back(mk(1, 0, 18'h1BEEF, 8'h66, '0, 512'h77, 4));
    wait_grant();
    @(posedge clk); #2;
    nrst = 0; read_D_ARB = 0; ready_L2_ARB = 1; read_data_L2_ARB = 512'h77;
    #1;
    chk_quiet("async_reset");
    q.delete();
    @(posedge clk); #1;
    chk_quiet("held_reset");
    chk("reset_rdata_passthrough", read_data_ARB_D, 512'h77);
    ready_L2_ARB = 0; read_data_L2_ARB = '0;
    nrst = 1;
    @(posedge clk); #1;
    chk("no_replay_after_reset", 512'({read_ARB_L2, write_ARB_L2}), 512'(0));

    read_I_ARB = 1; tag_I_ARB = 18'h00A0A; index_I_ARB = 8'h0A;
    read_D_ARB = 1; tag_D_ARB = 18'h00B0B; index_D_ARB = 8'h0B;
`ifdef L2_ARB_ROUND_ROBIN_EN
    q.push_back(mk(0, 0, 18'h00A0A, 8'h0A, '0, 512'h99, 2));
`else
    q.push_back(mk(1, 0, 18'h00B0B, 8'h0B, '0, 512'h99, 2));
`endif
    wait_grant();
    complete(2, 512'h99, 1);
    read_I_ARB = 0; read_D_ARB = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 512'(q.size()), 512'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
